// File: rtl/signed_binary_to_db_mc.sv
// Multi-channel signed PCM to dBFS converter with a decaying per-channel peak meter.
// One sample per start/done handshake. The magnitude is normalised one bit per cycle,
// log2 is taken with Mitchell's approximation, and the result is scaled by 20*log10(2).
// Optional build macro: DB_LUT_CORRECTION_EN adds a 16-entry log2 correction table
// indexed by the top mantissa nibble; undefined, the plain Mitchell estimate is used.
// Timing is the same in both builds.
//
// state | meaning
// IDLE  | waiting for start; sample and channel latched on acceptance
// ABS   | magnitude of the latched sample loaded, shift count cleared
// NORM  | zero magnitude finishes at once; else shift left until the MSB is set
// LOG   | Q.8 log2 relative to full scale registered
// MUL   | scale, round, saturate; result and peak registered, done pulsed

module signed_binary_to_db_mc #(
    parameter int IN_W       = 12,
    parameter int OUT_W      = 9,
    parameter int FRAC_BITS  = 1,
    parameter int NUM_CH     = 4,
    parameter int DECAY_STEP = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [IN_W-1:0]  input_binary,
    input  logic [CH_W-1:0]         channel,
    output logic signed [OUT_W-1:0] output_db,
    output logic [CH_W-1:0]         output_channel,
    output logic signed [OUT_W-1:0] peak_db,
    output logic                    done,
    output logic                    busy
);

    localparam int KW = $clog2(IN_W);
    localparam int LW = $clog2(IN_W) + 10;
    localparam int PW = LW + 11;
    localparam logic signed [OUT_W-1:0] DB_FLOOR = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] DB_CEIL  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0]    SCALE    = PW'(1541);
    localparam logic signed [PW-1:0]    RND_BIAS = PW'(2 ** (7 - FRAC_BITS));
    localparam logic signed [PW-1:0]    SAT_HI   = PW'(DB_CEIL);
    localparam logic signed [PW-1:0]    SAT_LO   = PW'(DB_FLOOR);

    typedef enum logic [2:0] {IDLE, ABS, NORM, LOG, MUL} state_t;

    state_t                  state, state_next;
    logic signed [IN_W-1:0]  x_reg;
    logic [CH_W-1:0]         ch_reg;
    logic [CH_W-1:0]         ch_in;
    logic [IN_W-1:0]         mag;
    logic [KW-1:0]           k;
    logic signed [LW-1:0]    l_reg;
    logic signed [OUT_W-1:0] peak [NUM_CH];

    logic                    fin;
    logic signed [OUT_W-1:0] fin_db;
    logic [IN_W-1:0]         mag_abs;
    logic [7:0]              frac;
    logic [4:0]              corr;
    logic signed [LW-1:0]    log_val;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    p_val;
    logic signed [PW-1:0]    r_val;
    logic signed [OUT_W-1:0] r_sat;
    logic signed [OUT_W-1:0] pk_cur;
    int                      pk_dec;
    logic signed [OUT_W-1:0] pk_sat;
    logic signed [OUT_W-1:0] new_peak;

    assign busy  = (state != IDLE);
    // Out-of-range tags fold onto channel 0 so the peak array is never overrun.
    assign ch_in = (int'(channel) >= NUM_CH) ? '0 : channel;

    // Datapath arithmetic: magnitude, log2 estimate, dB scaling and rounding.
    always_comb begin
        mag_abs = x_reg[IN_W-1] ? $unsigned(-x_reg) : $unsigned(x_reg);
        frac    = mag[IN_W-2 -: 8];
        corr    = 5'd0;
`ifdef DB_LUT_CORRECTION_EN
        case (frac[7:4])
            4'd0:  corr = 5'd3;
            4'd1:  corr = 5'd9;
            4'd2:  corr = 5'd14;
            4'd3:  corr = 5'd17;
            4'd4:  corr = 5'd20;
            4'd5:  corr = 5'd21;
            4'd6:  corr = 5'd22;
            4'd7:  corr = 5'd22;
            4'd8:  corr = 5'd21;
            4'd9:  corr = 5'd20;
            4'd10: corr = 5'd18;
            4'd11: corr = 5'd16;
            4'd12: corr = 5'd13;
            4'd13: corr = 5'd10;
            4'd14: corr = 5'd6;
            default: corr = 5'd2;
        endcase
`endif
        log_val = LW'(frac) + LW'(corr) - (LW'(k) << 8);
        prod    = PW'(l_reg) * SCALE;
        p_val   = prod >>> 8;
        r_val   = (p_val + RND_BIAS) >>> (8 - FRAC_BITS);
        if (r_val > SAT_HI) begin
            r_sat = DB_CEIL;
        end else if (r_val < SAT_LO) begin
            r_sat = DB_FLOOR;
        end else begin
            r_sat = r_val[OUT_W-1:0];
        end
    end

    // Next-state logic; the zero test uses the registered magnitude in NORM.
    always_comb begin
        state_next = state;
        fin        = 1'b0;
        fin_db     = DB_FLOOR;
        case (state)
            IDLE: if (start) state_next = ABS;
            ABS:  state_next = NORM;
            NORM: begin
                if (mag == '0) begin
                    fin        = 1'b1;
                    fin_db     = DB_FLOOR;
                    state_next = IDLE;
                end else if (mag[IN_W-1]) begin
                    state_next = LOG;
                end
            end
            LOG:  state_next = MUL;
            MUL: begin
                fin        = 1'b1;
                fin_db     = r_sat;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Peak hold: decayed old peak (floored) versus the new result.
    always_comb begin
        pk_cur = peak[ch_reg];
        pk_dec = int'(pk_cur) - DECAY_STEP;
        if (pk_dec < int'(DB_FLOOR)) begin
            pk_sat = DB_FLOOR;
        end else begin
            pk_sat = pk_dec[OUT_W-1:0];
        end
        new_peak = (fin_db > pk_sat) ? fin_db : pk_sat;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers, outputs and the per-channel peak store.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg          <= '0;
            ch_reg         <= '0;
            mag            <= '0;
            k              <= '0;
            l_reg          <= '0;
            output_db      <= '0;
            output_channel <= '0;
            peak_db        <= DB_FLOOR;
            done           <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) peak[i] <= DB_FLOOR;
        end else begin
            done <= fin;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg  <= input_binary;
                        ch_reg <= ch_in;
                    end
                end
                ABS: begin
                    mag <= mag_abs;
                    k   <= '0;
                end
                NORM: begin
                    if (!mag[IN_W-1] && (mag != '0)) begin
                        mag <= mag << 1;
                        k   <= k + KW'(1);
                    end
                end
                LOG: l_reg <= log_val;
                default: ;
            endcase
            if (fin) begin
                output_db      <= fin_db;
                output_channel <= ch_reg;
                peak_db        <= new_peak;
                peak[ch_reg]   <= new_peak;
            end
        end
    end

endmodule
